// File: rtl/gpio_in_filter.sv
// GPIO input conditioning: 2-flop sync, per-pin debounce, edge status.
// Output levels/enables are simply registered toward the pad cell.
module gpio_in_filter #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [WIDTH-1:0]     pad_c_i,
  input  logic [WIDTH-1:0]     out_i,
  input  logic [WIDTH-1:0]     oen_i,
  output logic [WIDTH-1:0]     pad_i_o,
  output logic [WIDTH-1:0]     pad_oen_o,
  input  logic [CNT_WIDTH-1:0] db_thres_i,
  input  logic [WIDTH-1:0]     rise_en_i,
  input  logic [WIDTH-1:0]     fall_en_i,
  input  logic [WIDTH-1:0]     irq_clr_i,
  output logic [WIDTH-1:0]     data_o,
  output logic [WIDTH-1:0]     irq_stat_o,
  output logic                 irq_o
);

  logic [WIDTH-1:0]     sync1;
  logic [WIDTH-1:0]     sync2;
  logic [WIDTH-1:0]     filt;
  logic [WIDTH-1:0]     filt_d;
  logic [WIDTH-1:0]     irq_stat;
  logic [WIDTH-1:0]     irq_stat_d;
  logic [WIDTH-1:0]     commit_rise;
  logic [WIDTH-1:0]     commit_fall;
  logic [CNT_WIDTH-1:0] cnt   [WIDTH];
  logic [CNT_WIDTH-1:0] cnt_d [WIDTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pad_i_o   <= '0;
      pad_oen_o <= '0;
    end else begin
      pad_i_o   <= out_i;
      pad_oen_o <= oen_i;
    end
  end

  always_comb begin
    filt_d = filt;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt[i];
      if (sync2[i] == filt[i]) begin
        cnt_d[i] = '0;
      end else if (cnt[i] >= db_thres_i) begin
        filt_d[i] = sync2[i];
        cnt_d[i]  = '0;
      end else if (!(&cnt[i])) begin
        cnt_d[i] = cnt[i] + 1'b1;
      end
    end
  end

  // A clear coinciding with a new edge loses to the set.
  always_comb begin
    commit_rise = filt_d & ~filt;
    commit_fall = ~filt_d & filt;
    irq_stat_d  = (irq_stat & ~irq_clr_i)
                | (commit_rise & rise_en_i)
                | (commit_fall & fall_en_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1    <= '0;
      sync2    <= '0;
      filt     <= '0;
      irq_stat <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1    <= pad_c_i;
      sync2    <= sync1;
      filt     <= filt_d;
      irq_stat <= irq_stat_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_d[i];
      end
    end
  end

  assign data_o     = filt;
  assign irq_stat_o = irq_stat;
  assign irq_o      = |irq_stat;

endmodule

// File: tb/tb_gpio_in_filter.sv
// Bench for gpio_in_filter: directed scenarios plus random traffic
// checked against a run-length reference model.
module tb_gpio_in_filter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  pad_c = '0;
  logic [7:0]  out_v = '0;
  logic [7:0]  oen = '0;
  logic [15:0] thres = '0;
  logic [7:0]  rise_en = '0;
  logic [7:0]  fall_en = '0;
  logic [7:0]  irq_clr = '0;
  logic [7:0]  pad_i;
  logic [7:0]  pad_oen;
  logic [7:0]  data;
  logic [7:0]  irq_stat;
  logic        irq;

  int total = 0;
  int bad = 0;

  logic [7:0] m_filt = '0;
  logic [7:0] m_irq = '0;
  logic [7:0] m_pi = '0;
  logic [7:0] m_poe = '0;
  logic [7:0] pad_hist[$] = '{8'h00, 8'h00};
  int         m_run[8] = '{default: 0};

  always #5 clk = ~clk;

  gpio_in_filter #(.WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .pad_c_i    (pad_c),
    .out_i      (out_v),
    .oen_i      (oen),
    .pad_i_o    (pad_i),
    .pad_oen_o  (pad_oen),
    .db_thres_i (thres),
    .rise_en_i  (rise_en),
    .fall_en_i  (fall_en),
    .irq_clr_i  (irq_clr),
    .data_o     (data),
    .irq_stat_o (irq_stat),
    .irq_o      (irq)
  );

  // Model: sync2 is the pad value two edges old; a pin flips once
  // its mismatch run has lasted more than thres cycles.
  task automatic tick();
    logic [7:0]  p, o, oe, re, fe, clr, s2, nf;
    logic [15:0] th;
    logic        r;
    p = pad_c; o = out_v; oe = oen; re = rise_en;
    fe = fall_en; clr = irq_clr; th = thres; r = rst;
    @(posedge clk);
    if (r) begin
      m_filt = '0; m_irq = '0; m_pi = '0; m_poe = '0;
      pad_hist = '{8'h00, 8'h00};
      foreach (m_run[i]) m_run[i] = 0;
    end else begin
      s2 = pad_hist[1];
      nf = m_filt;
      for (int i = 0; i < 8; i++) begin
        if (s2[i] == m_filt[i]) m_run[i] = 0;
        else if (m_run[i] >= int'(th)) begin
          nf[i] = s2[i];
          m_run[i] = 0;
        end else m_run[i]++;
      end
      m_irq = (m_irq & ~clr) | (nf & ~m_filt & re)
            | (~nf & m_filt & fe);
      m_filt = nf;
      void'(pad_hist.pop_back());
      pad_hist.push_front(p);
      m_pi = o;
      m_poe = oe;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    pad_c = 8'h3C; out_v = 8'h77; oen = 8'hF0;
    do_reset();
    pad_c = '0;
    total++;
    if ({data, irq_stat, pad_i, pad_oen, irq} !== 33'h0) begin
      bad++;
      $display("FAIL reset: data=%h irq_stat=%h pi=%h poe=%h irq=%b want all 0",
               data, irq_stat, pad_i, pad_oen, irq);
    end
  endtask

  task automatic test_output_path();
    out_v = 8'hA5; oen = 8'h0F;
    tick();
    total++;
    if (pad_i !== 8'hA5 || pad_oen !== 8'h0F) begin
      bad++;
      $display("FAIL out_path: pi=%h poe=%h want a5 0f", pad_i, pad_oen);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (pad_i !== 8'h00 || pad_oen !== 8'h00) begin
      bad++;
      $display("FAIL out_rst: pi=%h poe=%h want 00 00", pad_i, pad_oen);
    end
    out_v = '0; oen = '0;
  endtask

  task automatic test_rise_latency();
    int n;
    do_reset();
    thres = 16'd4; rise_en = 8'h01; fall_en = '0;
    pad_c = 8'h09;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      n = k;
      if (data[0]) break;
    end
    total++;
    if (n != 7 || data[0] !== 1'b1) begin
      bad++;
      $display("FAIL rise_lat: cycles=%0d want 7", n);
    end
    total++;
    if (irq_stat[0] !== 1'b1 || irq_stat[3] !== 1'b0
        || data[3] !== 1'b1) begin
      bad++;
      $display("FAIL rise_irq: stat=%h data=%h want bit0 set bit3 clr",
               irq_stat, data);
    end
  endtask

  task automatic test_glitch();
    int n;
    logic ok;
    do_reset();
    thres = 16'd4; rise_en = 8'h02; pad_c = 8'h02;
    repeat (3) tick();
    pad_c = 8'h00;
    ok = 1'b1;
    repeat (12) begin
      tick();
      if (data[1] !== 1'b0 || irq !== 1'b0) ok = 1'b0;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL glitch: data=%h irq=%b want 0 0", data, irq);
    end
    pad_c = 8'h02;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      n = k;
      if (data[1]) break;
    end
    total++;
    if (n != 7 || irq_stat[1] !== 1'b1) begin
      bad++;
      $display("FAIL glitch_hold: cycles=%0d stat=%h want 7 02",
               n, irq_stat);
    end
  endtask

  task automatic test_clear_collision();
    do_reset();
    thres = 16'd0; rise_en = 8'h04; fall_en = '0; pad_c = 8'h04;
    repeat (3) tick();
    total++;
    if (irq_stat !== 8'h04 || data !== 8'h04) begin
      bad++;
      $display("FAIL clr_setup: stat=%h data=%h want 04 04",
               irq_stat, data);
    end
    rise_en = '0; fall_en = 8'h04; pad_c = 8'h00;
    repeat (2) tick();
    irq_clr = 8'h04;
    tick();
    irq_clr = '0;
    total++;
    if (irq_stat[2] !== 1'b1 || data[2] !== 1'b0) begin
      bad++;
      $display("FAIL clr_collide: stat=%h data=%h want stat2=1 data2=0",
               irq_stat, data);
    end
    fall_en = '0;
    tick();
    total++;
    if (irq_stat[2] !== 1'b1) begin
      bad++;
      $display("FAIL en_drop: stat=%h want bit2 kept", irq_stat);
    end
    irq_clr = 8'h04;
    tick();
    irq_clr = '0;
    total++;
    if (irq_stat !== 8'h00 || irq !== 1'b0) begin
      bad++;
      $display("FAIL clr: stat=%h irq=%b want 00 0", irq_stat, irq);
    end
  endtask

  task automatic test_thres_change();
    do_reset();
    thres = 16'd100; rise_en = 8'h10; pad_c = 8'h10;
    repeat (52) tick();
    total++;
    if (data[4] !== 1'b0) begin
      bad++;
      $display("FAIL thr_early: data=%h want bit4 0", data);
    end
    thres = 16'd10;
    tick();
    total++;
    if (data[4] !== 1'b1 || irq_stat[4] !== 1'b1) begin
      bad++;
      $display("FAIL thr_drop: data=%h stat=%h want bit4 set",
               data, irq_stat);
    end
  endtask

  task automatic test_reset_high();
    pad_c = 8'hFF; rise_en = 8'hFF; fall_en = '0; thres = 16'd0;
    do_reset();
    tick();
    tick();
    total++;
    if (data !== 8'h00 || irq !== 1'b0) begin
      bad++;
      $display("FAIL rst_hi_early: data=%h irq=%b want 00 0", data, irq);
    end
    tick();
    total++;
    if (data !== 8'hFF || irq_stat !== 8'hFF) begin
      bad++;
      $display("FAIL rst_hi: data=%h stat=%h want ff ff", data, irq_stat);
    end
  endtask

  task automatic test_random();
    logic [7:0] flip;
    do_reset();
    thres = 16'd2;
    for (int c = 0; c < 1500; c++) begin
      flip = '0;
      for (int i = 0; i < 8; i++)
        if ($urandom_range(5) == 0) flip[i] = 1'b1;
      pad_c   = pad_c ^ flip;
      out_v   = 8'($urandom);
      oen     = 8'($urandom);
      rise_en = 8'($urandom);
      fall_en = 8'($urandom);
      irq_clr = 8'($urandom) & 8'($urandom) & 8'($urandom);
      if ($urandom_range(40) == 0) thres = 16'($urandom_range(6));
      rst = ($urandom_range(150) == 0);
      tick();
      total++;
      if (data !== m_filt || irq_stat !== m_irq || irq !== |m_irq
          || pad_i !== m_pi || pad_oen !== m_poe) begin
        bad++;
        $display("FAIL rand c%0d: d=%h s=%h i=%b pi=%h poe=%h want %h %h %b %h %h",
                 c, data, irq_stat, irq, pad_i, pad_oen,
                 m_filt, m_irq, |m_irq, m_pi, m_poe);
      end
    end
    rst = 1'b0;
    irq_clr = '0;
  endtask

  initial begin
    test_reset();
    test_output_path();
    test_rise_latency();
    test_glitch();
    test_clear_collision();
    test_thres_change();
    test_reset_high();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
